riffa_tx_arbiter: RTL
=====================

RIFFA_TX_ARBITER -- requirements
Module: riffa_tx_arbiter

Interface
REQ-001 The block SHALL have parameter C_PCI_DATA_WIDTH, default 32: RIFFA channel data width in bits, restricted to 32, 64 or 128.
REQ-002 The block SHALL have parameter NUM_SRC, default 4: number of AHIR output pipes sharing one TX channel, range 2..16.
REQ-003 The block SHALL have parameter BURST_BEATS, default 120: payload beats per TX transaction, range 1..65535.
REQ-004 The block SHALL have derived constant numWords = C_PCI_DATA_WIDTH/32.
REQ-005 The block SHALL have port CLK, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port src_data, input, NUM_SRC*C_PCI_DATA_WIDTH bits: source i occupies slice i.
REQ-008 The block SHALL have port src_valid, input, NUM_SRC bits: source i holds a valid beat.
REQ-009 The block SHALL have port src_ready, output, NUM_SRC bits: the beat is consumed when src_valid[i] and src_ready[i] are both 1.
REQ-010 The block SHALL have port CHNL_TX, output, 1 bit: RIFFA TX transaction active.
REQ-011 The block SHALL have port CHNL_TX_ACK, input, 1 bit: RIFFA acknowledge, informational only.
REQ-012 The block SHALL have port CHNL_TX_LEN, output, 32 bits: transaction length in 32-bit words.
REQ-013 The block SHALL have port CHNL_TX_DATA, output, C_PCI_DATA_WIDTH bits: TX data.
REQ-014 The block SHALL have port CHNL_TX_DATA_VALID, output, 1 bit: TX beat valid.
REQ-015 The block SHALL have port CHNL_TX_DATA_REN, input, 1 bit: a beat is accepted when VALID and REN are both 1.
REQ-016 The block SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-017 The block SHALL have port cur_src, output, 4 bits: registered grant index.

Function
REQ-018 The block SHALL implement exactly three states: IDLE, HDR and DATA.
REQ-019 In IDLE, when any src_valid bit is 1, the block SHALL register grant as the first valid index searching from (last_grant+1) mod NUM_SRC upward with wrap, then go to HDR; last_grant SHALL update to grant at the same time.
REQ-020 The block SHALL spend at least one cycle in IDLE between transactions.
REQ-021 In HDR and DATA the block SHALL drive CHNL_TX=1; in IDLE it SHALL drive CHNL_TX=0.
REQ-022 CHNL_TX_LEN SHALL be the constant (BURST_BEATS+1)*numWords.
REQ-023 In HDR the block SHALL drive CHNL_TX_DATA_VALID=1 and CHNL_TX_DATA = header, with bits[7:0] = grant, bits[31:16] = BURST_BEATS[15:0], and all other bits 0.
REQ-024 In HDR, on REN=1 the block SHALL clear beat_cnt and go to DATA.
REQ-025 In DATA the block SHALL pass data through combinationally: CHNL_TX_DATA = src_data[grant], CHNL_TX_DATA_VALID = src_valid[grant], src_ready[grant] = CHNL_TX_DATA_REN; latency SHALL be zero.
REQ-026 src_ready SHALL be 0 for every non-granted source, and for all sources outside DATA.
REQ-027 In DATA, beat_cnt (16 bits) SHALL increment on each accepted beat.
REQ-028 On the accept with beat_cnt == BURST_BEATS-1, the block SHALL go to IDLE, so exactly BURST_BEATS payload beats are sent.
REQ-029 The granted source stalling (src_valid=0) SHALL hold DATA indefinitely, with no timeout and no re-arbitration mid-burst.
REQ-030 A src_valid change on a non-granted source mid-burst SHALL have no effect until IDLE.
REQ-031 CHNL_TX_DATA SHALL be 0 in IDLE.
REQ-032 The block SHALL never drive CHNL_TX_DATA_VALID=1 while CHNL_TX=0.

Reset
REQ-033 RST=1 SHALL immediately force state=IDLE, grant=0, last_grant=NUM_SRC-1 (so source 0 is first priority), beat_cnt=0.
REQ-034 While RST=1, outputs SHALL be: CHNL_TX=0, CHNL_TX_DATA_VALID=0, CHNL_TX_DATA=0, src_ready=0, busy=0, cur_src=0; CHNL_TX_LEN SHALL remain its constant.
REQ-035 Reset mid-transaction SHALL abort the burst without completing it; after release, arbitration SHALL restart from source 0.

Structure
REQ-036 The state encoding, header field positions and width limits SHALL live in shared package riffa_ahir_pkg.
REQ-037 The block SHALL contain one sub-module, rr_pick, that is purely combinational and takes request vector and last_grant to produce grant index and any flag.

Verification
REQ-038 Verification SHALL cover: NUM_SRC=4, BURST_BEATS=3, only src 2 valid, REN=1 -> header 0x0003_0002, then 3 beats of src 2, CHNL_TX_LEN=4, one IDLE cycle between bursts.
REQ-039 Verification SHALL cover: all 4 sources valid continuously -> grant order 0,1,2,3,0.
REQ-040 Verification SHALL cover: REN toggling 1,0,1,0 during DATA -> beat_cnt advances only on REN=1, with no duplicated or lost beats.
REQ-041 Verification SHALL cover: granted source deasserts valid for 5 cycles mid-burst while others stay valid -> CHNL_TX held, grant unchanged, burst resumes.
REQ-042 Verification SHALL cover: RST pulse after 2 of 3 beats -> CHNL_TX=0 the same cycle; after release, src 0 is granted first when valid.
REQ-043 Verification SHALL cover: C_PCI_DATA_WIDTH=128, BURST_BEATS=1 -> CHNL_TX_LEN=8, header upper 96 bits 0.

Source files
------------

// File: rtl/riffa_ahir_pkg.sv
// Shared definitions for the AHIR-to-RIFFA TX path: arbiter states, header
// field layout and parameter limits.
package riffa_ahir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } tx_state_e;

    localparam int GRANT_W       = 4;
    localparam int BEAT_CNT_W    = 16;

    localparam int HDR_GRANT_LSB = 0;
    localparam int HDR_GRANT_W   = 8;
    localparam int HDR_BEATS_LSB = 16;
    localparam int HDR_BEATS_W   = 16;

    localparam int MIN_SRC       = 2;
    localparam int MAX_SRC       = 16;
    localparam int MAX_BURST     = 65535;

    // First word of every transaction: source index low, payload beat count high.
    function automatic logic [31:0] make_header(input logic [GRANT_W-1:0] grant,
                                                input logic [HDR_BEATS_W-1:0] beats);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_GRANT_LSB +: HDR_GRANT_W] = HDR_GRANT_W'(grant);
        hdr[HDR_BEATS_LSB +: HDR_BEATS_W] = beats;
        return hdr;
    endfunction

endpackage

// File: rtl/riffa_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_grant,
// wrapping to the lowest requester when nothing above it is asking.
module rr_pick
    import riffa_ahir_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [GRANT_W-1:0] last_grant_i,
    output logic [GRANT_W-1:0] grant_o,
    output logic               any_o
);

    logic [NUM_SRC-1:0] upper;
    logic [GRANT_W-1:0] first_upper;
    logic [GRANT_W-1:0] first_any;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_upper
            assign upper[gi] = req_i[gi] && (GRANT_W'(gi) > last_grant_i);
        end
    endgenerate

    // Scan downward so the lowest qualifying index is the last one written.
    always_comb begin
        first_upper = '0;
        first_any   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (upper[i]) begin
                first_upper = GRANT_W'(i);
            end
            if (req_i[i]) begin
                first_any = GRANT_W'(i);
            end
        end
    end

    assign any_o   = |req_i;
    assign grant_o = (|upper) ? first_upper : first_any;

endmodule

// File: rtl/riffa_tx_arbiter.sv
// Multiplexes several AHIR output pipes onto one RIFFA TX channel: a header
// beat naming the source, then a fixed-length burst passed through unregistered.
module riffa_tx_arbiter
    import riffa_ahir_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int NUM_SRC          = 4,
    parameter int BURST_BEATS      = 120
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [NUM_SRC*C_PCI_DATA_WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]                    src_valid,
    output logic [NUM_SRC-1:0]                    src_ready,
    output logic                                  CHNL_TX,
    input  logic                                  CHNL_TX_ACK,
    output logic [31:0]                           CHNL_TX_LEN,
    output logic [C_PCI_DATA_WIDTH-1:0]           CHNL_TX_DATA,
    output logic                                  CHNL_TX_DATA_VALID,
    input  logic                                  CHNL_TX_DATA_REN,
    output logic                                  busy,
    output logic [3:0]                            cur_src
);

    localparam int numWords = C_PCI_DATA_WIDTH / 32;
    localparam int SEL_W    = $clog2(NUM_SRC);
    localparam logic [BEAT_CNT_W-1:0] BEAT_FIELD = BEAT_CNT_W'(BURST_BEATS);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT  = BEAT_CNT_W'(BURST_BEATS - 1);

    tx_state_e                 state_q, state_d;
    logic [GRANT_W-1:0]        grant_q, grant_d;
    logic [GRANT_W-1:0]        last_grant_q, last_grant_d;
    logic [BEAT_CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic [GRANT_W-1:0]        pick_grant;
    logic                      pick_any;
    logic [SEL_W-1:0]          sel;
    logic                      data_ready;
    logic [C_PCI_DATA_WIDTH-1:0] header;
    logic [C_PCI_DATA_WIDTH-1:0] src_beat [NUM_SRC];
    logic                      ack_unused;

    // The acknowledge carries no information the burst sequencing needs.
    assign ack_unused = CHNL_TX_ACK;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_beat[gi]  = src_data[gi*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];
            assign src_ready[gi] = data_ready && (sel == SEL_W'(gi));
        end
    endgenerate

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .req_i        (src_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_grant),
        .any_o        (pick_any)
    );

    assign sel         = grant_q[SEL_W-1:0];
    assign header      = C_PCI_DATA_WIDTH'(make_header(grant_q, BEAT_FIELD));
    assign CHNL_TX_LEN = 32'((BURST_BEATS + 1) * numWords);
    assign busy        = (state_q != ST_IDLE);
    assign cur_src     = grant_q;

    // last_grant resets to the top index so source 0 wins the first arbitration.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(NUM_SRC - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        last_grant_d       = last_grant_q;
        beat_cnt_d         = beat_cnt_q;
        CHNL_TX            = 1'b0;
        CHNL_TX_DATA       = '0;
        CHNL_TX_DATA_VALID = 1'b0;
        data_ready         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d      = pick_grant;
                    last_grant_d = pick_grant;
                    state_d      = ST_HDR;
                end
            end
            ST_HDR: begin
                CHNL_TX            = 1'b1;
                CHNL_TX_DATA       = header;
                CHNL_TX_DATA_VALID = 1'b1;
                if (CHNL_TX_DATA_REN) begin
                    beat_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                // Zero-latency pass-through; a stalled source simply holds the burst.
                CHNL_TX            = 1'b1;
                CHNL_TX_DATA       = src_beat[sel];
                CHNL_TX_DATA_VALID = src_valid[sel];
                data_ready         = CHNL_TX_DATA_REN;
                if (src_valid[sel] && CHNL_TX_DATA_REN) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
